// File: rtl/stopwatch_bcd_counter.sv
// MM:SS stopwatch feeding the 4-digit scan display; BCD digits {mt, mu, st, su}.
// Optional lap-hold snapshot on `digits` when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_bcd_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int PRESC_W  = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clr,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic        lap,
  output logic        lap_active,
`endif
  output logic [15:0] digits,
  output logic        tick_o,
  output logic        running,
  output logic        ovf
);

  // state | meaning
  // IDLE  | cleared or reset, waiting for start
  // RUN   | prescaler advancing, digits step on terminal count
  // PAUSE | start dropped, prescaler and digits held
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  state_t             state, state_nx;
  logic [PRESC_W-1:0] presc;
  logic [15:0]        cnt, cnt_inc;
  logic               step, wrap;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)  state_nx = RUN;
      RUN:     if (!start) state_nx = PAUSE;
      PAUSE:   if (start)  state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  assign step = (state == RUN) && (presc == PRESC_MAX);

  // Ripple carry through the four BCD digits; wrap marks 99:59 -> 00:00.
  always_comb begin
    cnt_inc = cnt;
    wrap    = 1'b0;
    if (cnt[3:0] != 4'd9) begin
      cnt_inc[3:0] = cnt[3:0] + 4'd1;
    end else begin
      cnt_inc[3:0] = 4'd0;
      if (cnt[7:4] != 4'd5) begin
        cnt_inc[7:4] = cnt[7:4] + 4'd1;
      end else begin
        cnt_inc[7:4] = 4'd0;
        if (cnt[11:8] != 4'd9) begin
          cnt_inc[11:8] = cnt[11:8] + 4'd1;
        end else begin
          cnt_inc[11:8] = 4'd0;
          if (cnt[15:12] != 4'd9) begin
            cnt_inc[15:12] = cnt[15:12] + 4'd1;
          end else begin
            cnt_inc[15:12] = 4'd0;
            wrap           = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= IDLE;
      presc   <= '0;
      cnt     <= '0;
      tick_o  <= 1'b0;
      running <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == RUN);
      tick_o  <= step;
      if (state == RUN) presc <= step ? '0 : presc + PRESC_W'(1);
      if (step) begin
        cnt <= cnt_inc;
        if (wrap) ovf <= 1'b1;
      end
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        lap_q;
  logic [15:0] snap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lap_q      <= 1'b0;
      lap_active <= 1'b0;
      snap       <= '0;
    end else begin
      lap_q <= lap;
      if (lap && !lap_q) begin
        lap_active <= !lap_active;
        if (!lap_active) snap <= cnt;
      end
    end
  end

  // Both mux inputs are registers, so digits stays free of input paths.
  assign digits = lap_active ? snap : cnt;
`else
  assign digits = cnt;
`endif

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Upstream of the 4-digit seven-segment scan display. Produces the four BCD digits that the scanner multiplexes onto ds/seg.
- Counts elapsed time as MM:SS, from 00:00 to 99:59, driven by an internal tick prescaler.
- Run/pause is controlled by the same `start` level the display stage receives.
- Digit order on `digits`: [15:12] minute tens, [11:8] minute units, [7:4] second tens, [3:0] second units.

Parameters:
- TICK_DIV, default 50000000: clk cycles per count step (1 s at 50 MHz). Legal range ≥1. Benches use 4.
- PRESC_W, default 26: prescaler width. Must satisfy 2**PRESC_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset. Highest priority.
- start  input  1  run enable (level): 1 = count, 0 = pause.
- clr  input  1  synchronous clear of the count. Priority below rst.
- digits  output  16  four BCD digits, layout as in Overview.
- tick_o  output  1  one-cycle pulse, asserted on the same edge digits changes by a count step.
- running  output  1  high while the state machine is in RUN.
- ovf  output  1  sticky flag: the count wrapped 99:59 -> 00:00.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, prescaler=0, digits=16'h0000, tick_o=0, running=0, ovf=0.
- State machine, evaluated each edge when rst=0 and clr=0:
  - IDLE: start=1 -> RUN.
  - RUN: start=0 -> PAUSE.
  - PAUSE: start=1 -> RUN.
  - running is a registered decode of state==RUN.
- Counting happens only in cycles where the state is already RUN. This gives one cycle of latency from start being sampled high.
- Prescaler in RUN:
  - If prescaler==TICK_DIV-1: prescaler <= 0 and a step fires.
  - Otherwise prescaler increments.
- In PAUSE and IDLE the prescaler holds. A partial interval is kept across a pause.
- A step fires on the same edge: the digits increment and tick_o=1. tick_o=0 in every other cycle.
- Increment rules:
  - sec units: 0-9, carry out at 9.
  - sec tens: 0-5, carry out at 5.
  - min units: 0-9, carry out at 9.
  - min tens: 0-9.
  - 99:59 + step -> 00:00 and ovf <= 1. ovf holds until rst or clr.
- Digit values above the per-digit maximum never occur.
- clr=1 at an edge: prescaler=0, digits=0, ovf=0, tick_o=0, state=IDLE. clr wins over a step in the same cycle. If start=1 while clr=1, the state still goes to IDLE; RUN is entered on the next edge that has clr=0.
- rst asserted mid-run: all outputs return to reset values on that edge. The prescaler phase is not retained.
- TICK_DIV=1: a step fires on every RUN cycle.
- All outputs are registered. No combinational path from any input to any output.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- When defined:
  - Adds input `lap` (1 bit) and output `lap_active` (1 bit).
  - A rising edge of lap (registered edge detect) toggles lap_active.
  - While lap_active=1, digits shows a snapshot taken on the edge lap_active set. The internal count and tick_o continue.
  - Clearing lap_active returns digits to the live count on the next edge.
  - rst and clr force lap_active=0.
- When not defined: no lap or lap_active ports, and digits always shows the live count.

Test Plan (TICK_DIV=4):
- rst=1 for 10 cycles, start=1 -> digits=16'h0000, tick_o=0, running=0, ovf=0 throughout.
- Release rst with start=1 -> running=1 after 1 edge. First tick_o and digits=16'h0001 on the 5th edge after release. Then one step every 4 cycles; 16'h0009 -> 16'h0010.
- Run through the carry boundaries -> 16'h0059 -> 16'h0100; 16'h0959 -> 16'h1000; 16'h9959 -> 16'h0000 with ovf=1. ovf stays 1 through further steps until clr.
- Pause: start=0 for 20 cycles when prescaler=2 -> running=0, digits and prescaler frozen, no tick_o. After start=1: RUN next edge, step fires 2 RUN cycles later.
- clr=1 in the same cycle a step would fire (digits=16'h0123) -> digits=16'h0000, tick_o=0, state IDLE. Re-enters RUN the edge after clr drops.
- rst=1 mid-count at digits=16'h0042 -> all outputs at reset values on the next edge.
- With STOPWATCH_LAP_HOLD_EN: pulse lap at 16'h0012 -> digits holds 16'h0012 while ticks continue. Second pulse -> digits shows the live value (e.g. 16'h0015).
